// File: rtl/mux_lab_pkg.sv
// Shared types and constants for the 4-to-1 mux scan sequencer.
// No timing of its own; used by the sequencer and its settle timer.
package mux_lab_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    localparam int NUM_CH  = 4;
    localparam int SEL_W   = 2;
    localparam int TIMER_W = 8;

    // Channel index equals select code equals bit position in the sample word.
    localparam logic [SEL_W-1:0] CH_A = 2'd0;
    localparam logic [SEL_W-1:0] CH_B = 2'd1;
    localparam logic [SEL_W-1:0] CH_C = 2'd2;
    localparam logic [SEL_W-1:0] CH_D = 2'd3;

endpackage

// File: rtl/settle_timer.sv
// Loadable 8-bit down-counter with a zero flag; load has priority over enable.
// Zero reflects the registered count; no backpressure.
module settle_timer
    import mux_lab_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               en,
    output logic               zero
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks the mux selects A..D, settles SETTLE_CYCLES per channel, captures F, and
// publishes the 4-bit word with a one-cycle valid 4*(SETTLE_CYCLES+1)+1 edges after start.
module mux_scan_sequencer
    import mux_lab_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter bit CONTINUOUS    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mux_f,
    output logic              sel_s1,
    output logic              sel_s0,
    output logic              busy,
    output logic [NUM_CH-1:0] sample,
    output logic              sample_valid
);

    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(SETTLE_CYCLES - 1);

    state_t             state;
    logic [SEL_W-1:0]   channel;
    logic [NUM_CH-1:0]  buffer;
    logic               timer_load;
    logic               timer_en;
    logic               timer_zero;

    // Reload whenever the FSM is about to enter SETTLE.
    assign timer_load = !abort && (((state == IDLE) && start) ||
                                   ((state == CAPTURE) && (channel != CH_D)) ||
                                   ((state == DONE) && CONTINUOUS));
    assign timer_en   = (state == SETTLE) && !abort;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (RELOAD),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            channel      <= CH_A;
            buffer       <= '0;
            busy         <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    channel <= CH_A;
                    if (start && !abort) begin
                        state <= SETTLE;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state   <= IDLE;
                        channel <= CH_A;
                        buffer  <= '0;
                        busy    <= 1'b0;
                    end else if (timer_zero) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        state   <= IDLE;
                        channel <= CH_A;
                        buffer  <= '0;
                        busy    <= 1'b0;
                    end else begin
                        buffer[channel] <= mux_f;
                        if (channel == CH_D) begin
                            state <= DONE;
                        end else begin
                            channel <= channel + SEL_W'(1);
                            state   <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    // The result is published even when abort arrives here.
                    sample       <= buffer;
                    sample_valid <= 1'b1;
                    channel      <= CH_A;
                    if (CONTINUOUS && !abort) begin
                        state <= SETTLE;
                    end else begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        buffer <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    channel <= CH_A;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign sel_s1 = channel[1];
    assign sel_s0 = channel[0];

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomised bench for the mux scan sequencer: single-scan and continuous instances
// checked cycle by cycle against a timeline model derived from settle/capture arithmetic.
module tb_mux_scan_sequencer;

    localparam int SC0  = 2;
    localparam int LAT0 = 4 * (SC0 + 1) + 1;
    localparam int SC1  = 1;
    localparam int PER1 = 4 * (SC1 + 1) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, start0, abort0, mux_f0;
    logic       sel_s1_0, sel_s0_0, busy0, valid0;
    logic [3:0] sample0;
    logic       rst1, start1, abort1, mux_f1;
    logic       sel_s1_1, sel_s0_1, busy1, valid1;
    logic [3:0] sample1;

    int total = 0;
    int bad   = 0;
    logic [3:0] sample_m0 = 4'b0000;
    logic [3:0] sample_m1 = 4'b0000;

    mux_scan_sequencer #(.SETTLE_CYCLES(SC0), .CONTINUOUS(1'b0)) dut0 (
        .clk(clk), .rst(rst0), .start(start0), .abort(abort0), .mux_f(mux_f0),
        .sel_s1(sel_s1_0), .sel_s0(sel_s0_0), .busy(busy0),
        .sample(sample0), .sample_valid(valid0)
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(SC1), .CONTINUOUS(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .abort(abort1), .mux_f(mux_f1),
        .sel_s1(sel_s1_1), .sel_s0(sel_s0_1), .busy(busy1),
        .sample(sample1), .sample_valid(valid1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk0(input int e_sel, input int e_busy, input int e_valid, input int e_sample);
        chk("sel0",    int'({sel_s1_0, sel_s0_0}), e_sel);
        chk("busy0",   int'(busy0),   e_busy);
        chk("valid0",  int'(valid0),  e_valid);
        chk("sample0", int'(sample0), e_sample);
    endtask

    task automatic chk1(input int e_sel, input int e_busy, input int e_valid, input int e_sample);
        chk("sel1",    int'({sel_s1_1, sel_s0_1}), e_sel);
        chk("busy1",   int'(busy1),   e_busy);
        chk("valid1",  int'(valid1),  e_valid);
        chk("sample1", int'(sample1), e_sample);
    endtask

    // One scan on the single-shot instance; abort_at is the edge (counted from the
    // start edge) at which abort is sampled, or -1 for none. F is noise except on
    // the edge where each channel is due to be captured.
    task automatic scan0(input logic [3:0] d, input int abort_at, input bit hold);
        int   ch;
        bit   aborted;
        logic [1:0] ci;
        start0 = 1'b1;
        mux_f0 = 1'($urandom);
        @(posedge clk); #1;
        if (!hold) start0 = 1'b0;
        for (int n = 1; n <= LAT0 + 2; n++) begin
            abort0 = (n == abort_at);
            ch = n / (SC0 + 1);
            if ((n % (SC0 + 1) == 0) && ch >= 1 && ch <= 4) begin
                ci = 2'(ch - 1);
                mux_f0 = d[ci];
            end else begin
                mux_f0 = 1'($urandom);
            end
            @(posedge clk); #1;
            abort0 = 1'b0;
            if (n == LAT0) start0 = 1'b0;
            aborted = (abort_at > 0) && (abort_at < LAT0) && (n >= abort_at);
            if (aborted) begin
                chk0(0, 0, 0, int'(sample_m0));
            end else if (n < LAT0) begin
                chk0((ch > 3) ? 3 : ch, 1, 0, int'(sample_m0));
            end else begin
                if (n == LAT0) sample_m0 = d;
                chk0(0, 0, (n == LAT0) ? 1 : 0, int'(sample_m0));
            end
        end
    endtask

    // Continuous instance: scans back to back, abort lands on the DONE edge of the last scan.
    task automatic cont_run(input int nscans);
        logic [3:0] dq [0:7];
        logic [2:0] qi;
        logic [1:0] ci;
        int q, r, lastn;
        dq[0] = 4'b0011;
        for (int i = 1; i < 8; i++) dq[i] = 4'($urandom);
        lastn = PER1 * nscans;
        start1 = 1'b1;
        mux_f1 = 1'($urandom);
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int n = 1; n <= lastn + 3; n++) begin
            q = n / PER1;
            r = n % PER1;
            abort1 = (n == lastn);
            if (r != 0 && (r % 2) == 0) begin
                qi = 3'(q);
                ci = 2'(r / 2 - 1);
                mux_f1 = dq[qi][ci];
            end else begin
                mux_f1 = 1'($urandom);
            end
            @(posedge clk); #1;
            abort1 = 1'b0;
            if (n > lastn) begin
                chk1(0, 0, 0, int'(sample_m1));
            end else if (r == 0) begin
                qi = 3'(q - 1);
                sample_m1 = dq[qi];
                chk1(0, (n == lastn) ? 0 : 1, 1, int'(sample_m1));
            end else begin
                chk1((r / 2 > 3) ? 3 : r / 2, 1, 0, int'(sample_m1));
            end
        end
    endtask

    initial begin
        int a;
        rst0 = 1'b1; rst1 = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; mux_f0 = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; mux_f1 = 1'b0;
        #2;
        chk0(0, 0, 0, 0);
        chk1(0, 0, 0, 0);
        #10;
        rst0 = 1'b0; rst1 = 1'b0;
        @(posedge clk); #1;

        scan0(4'b1101, -1, 1'b0);
        scan0(4'b1110, -1, 1'b0);
        scan0(4'b0001, -1, 1'b0);
        scan0(4'b1010, 7, 1'b0);
        scan0(4'b0110, -1, 1'b0);
        scan0(4'b1001, LAT0, 1'b0);
        scan0(4'($urandom), -1, 1'b1);

        for (int i = 0; i < 12; i++) begin
            a = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, LAT0));
            scan0(4'($urandom), a, 1'b0);
        end

        // start and abort together in IDLE: abort wins.
        start0 = 1'b1; abort0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; abort0 = 1'b0;
        chk0(0, 0, 0, int'(sample_m0));
        @(posedge clk); #1;
        chk0(0, 0, 0, int'(sample_m0));

        // Asynchronous reset between edges while settling on channel C.
        scan0(4'b1011, -1, 1'b0);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk); #1;
        end
        chk("sel0_pre_rst", int'({sel_s1_0, sel_s0_0}), 2);
        #2;
        rst0 = 1'b1;
        #1;
        sample_m0 = 4'b0000;
        chk0(0, 0, 0, 0);
        #3;
        rst0 = 1'b0;
        @(posedge clk); #1;
        chk0(0, 0, 0, 0);
        scan0(4'($urandom), -1, 1'b0);

        cont_run(int'($urandom_range(3, 5)));
        cont_run(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
